// File: rtl/seven_segment_scan_driver_if.sv
// rtl/seven_segment_scan_driver_if.sv - value/strobe bundle between lab logic and the scan driver
interface seven_segment_scan_driver_if #(
  parameter int w_digit = 8
);
  logic [4*w_digit-1:0] number;
  logic [w_digit-1:0]   dots;
  logic                 update;
  logic                 blank;
  logic [7:0]           abcdefgh;
  logic [w_digit-1:0]   digit;
  logic                 frame_start;

  modport master (
    output number, dots, update, blank,
    input  abcdefgh, digit, frame_start
  );

  modport slave (
    input  number, dots, update, blank,
    output abcdefgh, digit, frame_start
  );
endinterface

// File: rtl/seven_segment_scan_driver.sv
// rtl/seven_segment_scan_driver.sv - multiplexed seven-segment scan with frame-synchronous updates
// Optional leading-zero blanking: SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
module seven_segment_scan_driver #(
  parameter int clk_mhz    = 50,
  parameter int w_digit    = 8,
  parameter int refresh_hz = 500
) (
  input  logic clk,
  input  logic rst_n,
  seven_segment_scan_driver_if.slave bus
);
  localparam int period_raw = (clk_mhz * 1000000) / (refresh_hz * w_digit);
  localparam int period     = (period_raw < 1) ? 1 : period_raw;
  localparam int cnt_w      = (period > 1) ? $clog2(period) : 1;
  localparam int idx_w      = (w_digit > 1) ? $clog2(w_digit) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(period - 1);
  localparam logic [idx_w-1:0] idx_last = idx_w'(w_digit - 1);

  logic [cnt_w-1:0]     cnt;
  logic [idx_w-1:0]     idx;
  logic [4*w_digit-1:0] stage_num, disp_num, src_num;
  logic [w_digit-1:0]   stage_dots, disp_dots, src_dots;
  logic [w_digit-1:0]   digit_next;
  logic [3:0]           nib;
  logic                 dot;
  logic [6:0]           seg;
  logic                 tick, boundary;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h7E;  4'h1: seg7 = 7'h30;  4'h2: seg7 = 7'h6D;  4'h3: seg7 = 7'h79;
      4'h4: seg7 = 7'h33;  4'h5: seg7 = 7'h5B;  4'h6: seg7 = 7'h5F;  4'h7: seg7 = 7'h70;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h7B;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h1F;
      4'hC: seg7 = 7'h4E;  4'hD: seg7 = 7'h3D;  4'hE: seg7 = 7'h4F;  default: seg7 = 7'h47;
    endcase
  endfunction

  assign tick     = (cnt == cnt_last);
  assign boundary = tick && (idx == '0);

  // Digit 0 of a new frame decodes straight from staging so the whole frame is one snapshot.
  always_comb begin
    src_num    = boundary ? stage_num  : disp_num;
    src_dots   = boundary ? stage_dots : disp_dots;
    nib        = 4'h0;
    dot        = 1'b0;
    digit_next = '0;
    for (int i = 0; i < w_digit; i++) begin
      if (idx == idx_w'(i)) begin
        nib           = src_num[4*i +: 4];
        dot           = src_dots[i];
        digit_next[i] = 1'b1;
      end
    end
  end

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
  logic upper_zero;

  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < w_digit; i++) begin
      if ((idx_w'(i) >= idx) && (src_num[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
    end
    seg = ((idx != '0) && upper_zero) ? 7'h00 : seg7(nib);
  end
`else
  always_comb begin
    seg = seg7(nib);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt             <= '0;
      idx             <= '0;
      stage_num       <= '0;
      stage_dots      <= '0;
      disp_num        <= '0;
      disp_dots       <= '0;
      bus.abcdefgh    <= 8'h00;
      bus.digit       <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      cnt             <= tick ? '0 : cnt + 1'b1;
      bus.frame_start <= boundary;
      if (bus.update) begin
        stage_num  <= bus.number;
        stage_dots <= bus.dots;
      end
      if (tick) begin
        bus.digit    <= digit_next;
        bus.abcdefgh <= bus.blank ? 8'h00 : {seg, dot};
        idx          <= (idx == idx_last) ? '0 : idx + 1'b1;
      end
      if (boundary) begin
        disp_num  <= stage_num;
        disp_dots <= stage_dots;
      end
    end
  end
endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// tb/tb_seven_segment_scan_driver.sv - directed and randomized checks of the scan driver against a frame-snapshot model
module tb_seven_segment_scan_driver;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [15:0] pend_num, shown_num;
  logic [3:0]  pend_dots, shown_dots;
  logic [6:0]  hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  seven_segment_scan_driver_if #(.w_digit(4)) bus ();

  seven_segment_scan_driver #(
    .clk_mhz   (1),
    .w_digit   (4),
    .refresh_hz(125000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [15:0] v, input logic [3:0] d, input int pos);
    logic [15:0] upper;
    logic [6:0]  s;
    upper = v >> (4 * pos);
    s     = hex_tab[upper[3:0]];
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    if (pos > 0 && upper == 16'h0) s = 7'h00;
`endif
    return {s, d[pos]};
  endfunction

  // One scan slot: tick edge then hold edge; upd_mode 1 captures on the tick edge, 2 on the hold edge.
  task automatic slot(input int pos, input bit blk, input int upd_mode,
                      input logic [15:0] nn, input logic [3:0] nd);
    logic [7:0] exp_seg;
    if (pos == 0) begin
      shown_num  = pend_num;
      shown_dots = pend_dots;
    end
    bus.blank  = blk;
    bus.number = nn;
    bus.dots   = nd;
    bus.update = (upd_mode == 1);
    step();
    if (upd_mode == 1) begin
      pend_num  = nn;
      pend_dots = nd;
    end
    exp_seg = blk ? 8'h00 : seg_of(shown_num, shown_dots, pos);
    chk($sformatf("digit_p%0d", pos), 32'(bus.digit), 32'(4'b0001 << pos));
    chk($sformatf("seg_p%0d", pos), 32'(bus.abcdefgh), 32'(exp_seg));
    chk($sformatf("fs_p%0d", pos), 32'(bus.frame_start), 32'(pos == 0));
    bus.update = (upd_mode == 2);
    step();
    if (upd_mode == 2) begin
      pend_num  = nn;
      pend_dots = nd;
    end
    bus.update = 1'b0;
    chk($sformatf("hold_digit_p%0d", pos), 32'(bus.digit), 32'(4'b0001 << pos));
    chk($sformatf("hold_seg_p%0d", pos), 32'(bus.abcdefgh), 32'(exp_seg));
    chk($sformatf("hold_fs_p%0d", pos), 32'(bus.frame_start), 32'(0));
  endtask

  task automatic quiet_frame(input bit blk);
    for (int p = 0; p < 4; p++) slot(p, blk, 0, 16'h0, 4'h0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    pend_num   = 16'h0;
    pend_dots  = 4'h0;
    shown_num  = 16'h0;
    shown_dots = 4'h0;
    rst_n      = 1'b0;
    bus.number = 16'h0;
    bus.dots   = 4'h0;
    bus.update = 1'b0;
    bus.blank  = 1'b0;

    repeat (3) step();
    chk("reset_digit", 32'(bus.digit), 32'(0));
    chk("reset_seg", 32'(bus.abcdefgh), 32'(0));
    chk("reset_fs", 32'(bus.frame_start), 32'(0));
    rst_n = 1'b1;
    step();
    chk("pre_tick_digit", 32'(bus.digit), 32'(0));
    chk("pre_tick_seg", 32'(bus.abcdefgh), 32'(0));

    quiet_frame(1'b0);
    quiet_frame(1'b0);

    slot(0, 1'b0, 0, 16'h0, 4'h0);
    slot(1, 1'b0, 2, 16'h1234, 4'h0);
    slot(2, 1'b0, 0, 16'h0, 4'h0);
    slot(3, 1'b0, 0, 16'h0, 4'h0);
    slot(0, 1'b0, 0, 16'h0, 4'h0);
    slot(1, 1'b0, 0, 16'h0, 4'h0);
    slot(2, 1'b0, 2, 16'h1234, 4'b0010);
    slot(3, 1'b0, 0, 16'h0, 4'h0);
    quiet_frame(1'b0);
    quiet_frame(1'b1);

    slot(0, 1'b0, 0, 16'h0, 4'h0);
    slot(1, 1'b0, 0, 16'h0, 4'h0);
    slot(2, 1'b0, 0, 16'h0, 4'h0);
    slot(3, 1'b0, 2, 16'h0042, 4'h0);
    quiet_frame(1'b0);

    slot(0, 1'b0, 1, 16'hABCD, 4'hF);
    slot(1, 1'b0, 0, 16'h0, 4'h0);
    slot(2, 1'b0, 0, 16'h0, 4'h0);
    slot(3, 1'b0, 0, 16'h0, 4'h0);
    quiet_frame(1'b0);

    for (int f = 0; f < 30; f++) begin
      for (int p = 0; p < 4; p++) begin
        logic [15:0] masks [4] = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
        logic [15:0] nn;
        int          mode;
        nn   = 16'($urandom) & masks[$urandom_range(0, 3)];
        mode = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
        slot(p, ($urandom_range(0, 7) == 0), mode, nn, 4'($urandom));
      end
    end

    slot(0, 1'b0, 0, 16'h0, 4'h0);
    slot(1, 1'b0, 0, 16'h0, 4'h0);
    step();
    chk("mid_frame_digit", 32'(bus.digit), 32'(4'b0100));
    rst_n = 1'b0;
    step();
    chk("mid_reset_digit", 32'(bus.digit), 32'(0));
    chk("mid_reset_seg", 32'(bus.abcdefgh), 32'(0));
    chk("mid_reset_fs", 32'(bus.frame_start), 32'(0));
    rst_n     = 1'b1;
    pend_num  = 16'h0;
    pend_dots = 4'h0;
    step();
    chk("restart_pre_tick_digit", 32'(bus.digit), 32'(0));
    quiet_frame(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seven_segment_scan_driver.md
# seven_segment_scan_driver

Time-multiplexed driver for a common-strobe seven-segment display of `w_digit` digits. It is the parametrised successor to the fixed 8-digit `abcdefgh`/`digit` path that top-level wrappers wire to `uo_out`/`uio_out`. The digit count and refresh rate are set by parameters. It adds tear-free frame-synchronous updates, a global blank and optional leading-zero blanking. It sits between lab logic that produces a hex number and the board pins.

## Interface

Parameters:
- `clk_mhz`, 50: system clock frequency in MHz.
- `w_digit`, 8: number of digits, 1..16.
- `refresh_hz`, 500: full-frame refresh rate in Hz.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `number`  in  `4*w_digit`: hex value; nibble i drives digit i, where nibble 0 is the least significant.
- `dots`  in  `w_digit`: decimal point per digit, active-high.
- `update`  in  1: single-cycle pulse that captures `number`/`dots` into staging.
- `blank`  in  1: forces all segments off while high.
- `abcdefgh`  out  8: segments, active-high; bit 7 = a … bit 1 = g, bit 0 = h (dot).
- `digit`  out  `w_digit`: one-hot digit select, active-high.
- `frame_start`  out  1: one-cycle pulse when digit 0 is driven.

## Operation

- **Prescaler:** `period = max(1, clk_mhz*1_000_000 / (refresh_hz*w_digit))`, computed at elaboration. The counter runs 0..period-1 and wraps. `tick` is asserted when the counter equals period-1.
- **Scan index:** `idx` runs 0..w_digit-1. Each tick drives digit `idx`, then sets `idx <= (idx == w_digit-1) ? 0 : idx+1`.
- **Staging:** `update` high loads `stage_num <= number` and `stage_dots <= dots`. The most recent pulse wins.
- **Frame boundary:** on a tick with `idx == 0`:
  - `disp_num <= stage_num` and `disp_dots <= stage_dots`.
  - The digit-0 decode in that same cycle uses the staging values.
  - A whole frame therefore always comes from one snapshot, so no tearing.
- **On every tick (registered):**
  - `digit <= 1 << idx`.
  - `abcdefgh <= {seg7(nibble idx), dot idx}`, or `8'h00` if `blank` is high.
- **Hex table for a..g:**
  - 0 = 7E, 1 = 30, 2 = 6D, 3 = 79, 4 = 33, 5 = 5B, 6 = 5F, 7 = 70.
  - 8 = 7F, 9 = 7B, A = 77, b = 1F, C = 4E, d = 3D, E = 4F, F = 47.
  - These are 7-bit values, shifted left by one into `abcdefgh`.
- **`blank`:** sampled only at ticks. Scanning and `frame_start` continue while blanked. `digit` keeps selecting.
- **`w_digit == 1`:** `idx` stays 0 and every tick is a frame boundary.
- **Reset** (any cycle, including mid-frame):
  - counter = 0, `idx` = 0, staging and display registers = 0.
  - `abcdefgh = 8'h00`, `digit = 0`, `frame_start = 0`.

## Timing

- All outputs are registered and change only on the cycle after a tick edge. They hold between ticks.
- The first tick comes `period` cycles after `rst_n` deasserts. `digit` reads 0 until then.
- `frame_start` is high for exactly the one cycle in which `digit` becomes `1` after a change.
- **Update latency:** an `update` takes effect at the next frame boundary strictly after the capture edge.
  - `update` on the same edge as a frame-boundary tick: the display loads the old staging, and the new value appears one frame later.
- `period`-wide counter: `$clog2(period)` bits, minimum 1.

## Configuration

- Macro: `SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN`.
- **Defined:**
  - Digit i > 0 has its a..g segments forced to 0 when all `disp_num` nibbles ≥ i are zero. In the boundary cycle the check uses `stage_num`.
  - Dots are still shown.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- **Undefined:** all digits are shown, including leading zeros. No blanking logic is present.

## Test plan

Parameters for all scenarios: `clk_mhz=1`, `refresh_hz=125000`, `w_digit=4`, giving `period=2`.

- **Reset/first tick:** hold `rst_n=0` for 3 cycles, then release.
  - Outputs read 0 for 2 cycles.
  - Then `digit=4'b0001` with `frame_start=1` for one cycle, and `abcdefgh=8'hFC`.
- **Scan order:** steady state.
  - `digit` sequence is 0001, 0010, 0100, 1000, 0001, each held 2 cycles.
  - `frame_start` pulses every 8 cycles.
- **Update sync:** pulse `update` with `number=16'h1234` mid-frame while the display holds 0.
  - The rest of the current frame shows FC.
  - The next frame shows digit0 = 8'h66, digit1 = 8'hF2, digit2 = 8'hDA, digit3 = 8'h60.
- **Dots and blank:**
  - `dots=4'b0010` gives digit1 with bit 0 set.
  - Asserting `blank` across one frame gives `abcdefgh=0` for all digits, while `digit` keeps scanning.
- **Leading-zero (macro defined):** `number=16'h0042`.
  - digit3 = 8'h00, digit2 = 8'h00, digit1 = 8'h66, digit0 = 8'hDA.
  - Without the macro, digit3 and digit2 = 8'hFC.
- **Reset mid-frame:** drive `rst_n=0` while `digit=4'b0100`.
  - Next cycle: `digit=0`, `abcdefgh=0`.
  - After release, scanning restarts at digit 0 showing 8'hFC, because the staging registers were cleared.
